ora_count_multi: RTL and testbench
==================================

// Module: ora_count_multi
// PURPOSE
//  Multi-channel counting output response analyzer (ORA #3, next generation). Counts ones or
//  transitions on CH CUT output lines over a programmable test window. At window end, compares
//  each channel count against a golden value and reports per-channel pass/fail.
//  Sits between the CUT outputs and the LBIST controller, which issues start and consumes done/pass.
// PARAMETERS
//  CH        4    number of CUT output channels analysed in parallel
//  BITS      16   width of each channel counter
//  LEN_BITS  16   width of the test-window length (sampled cycles)
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst        in   1          reset; synchronous, active-high
//  start      in   1          begin a test window (accepted in IDLE or DONE only)
//  mode       in   1          0 = ones count, 1 = transition count; latched on start
//  sat_en     in   1          1 = saturate at all-ones, 0 = wrap; latched on start
//  test_len   in   LEN_BITS   number of sampled cycles; latched on start
//  din        in   CH         CUT response bits, one per channel
//  golden     in   CH*BITS    expected counts, channel i at [i*BITS +: BITS]
//  busy       out  1          high in RUN and CMP
//  done       out  1          high in DONE
//  pass       out  1          valid when done: 1 iff fail_mask == 0
//  fail_mask  out  CH         bit i set iff count[i] != golden[i]; valid when done
//  ovf        out  CH         sticky per channel: counter reached all-ones then got another increment
//  counts     out  CH*BITS    live channel counts, same packing as golden
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; counts, prev, ovf, fail_mask, window counter = 0.
//    busy=0, done=0, pass=0. Reset overrides everything, including mid-RUN.
//  - FSM IDLE -> RUN -> CMP -> DONE. DONE -> RUN on start. Otherwise DONE holds.
//  - start in IDLE/DONE: latch mode/sat_en/test_len; clear counts, prev, ovf, fail_mask, pass, win.
//    Next state is RUN if test_len != 0, else CMP (all counts zero). start in RUN/CMP is ignored.
//  - RUN: every cycle sample din (first sample is the cycle after start accepted). Per channel:
//    inc_i = mode ? (din[i] ^ prev[i]) : din[i]. Then prev[i] <= din[i].
//    prev cleared to 0 on start, so an initial 1 counts as a transition.
//    win increments per sample. When win == test_len-1 on a sample cycle, next state is CMP.
//    Total samples = test_len exactly.
//  - Increment at count == all-ones: sat_en=1 -> hold all-ones; sat_en=0 -> wrap to 0.
//    Either way ovf[i] <= 1 (sticky until next start/rst).
//  - CMP (1 cycle): fail_mask[i] <= (count[i] != golden[i]); pass <= (all equal). golden is
//    sampled only in this cycle. Next state DONE.
//  - DONE: done=1; counts, fail_mask, pass, ovf held stable until next start or rst.
//  - Latency: start accepted at cycle t -> done rises at t+test_len+2 (test_len>0), t+2 (test_len=0).
//  - Widths: counts are unsigned BITS. win is LEN_BITS unsigned; max window 2^LEN_BITS-1.
// STRUCTURE
//  - Package ora_pkg: state typedef (IDLE, RUN, CMP, DONE), mode constants
//    MODE_ONES=1'b0, MODE_TRANS=1'b1.
//  - Sub-module ora_count_chan (#BITS): one channel. Inputs clk, rst, clr, en, mode, sat_en, din.
//    Outputs count, ovf. Generated CH times. Top holds FSM, window counter, compare.
// TESTING
//  1. Ones mode, CH=4, test_len=8, din=4'b0101 constant, golden={0,8,0,8} -> counts {0,8,0,8},
//     pass=1, done at t+10.
//  2. Transition mode, din[0] toggles every cycle, test_len=6 -> count[0]=6; din[1]=1 constant ->
//     count[1]=1 (initial edge only).
//  3. Wrap vs saturate, BITS=4, din=all-ones, test_len=20: sat_en=0 -> counts=4, ovf=all-ones;
//     sat_en=1 -> counts=15, ovf=all-ones.
//  4. Mismatch: test 1 with golden[2]=1 -> fail_mask=4'b0100, pass=0. Also test_len=0 ->
//     done at t+2, counts 0.
//  5. start pulsed mid-RUN -> ignored, window length unchanged. rst asserted mid-RUN ->
//     next cycle IDLE, all outputs 0.
//  6. Back-to-back: start in DONE -> counts/ovf/fail_mask cleared, new window runs with new mode.

Source files
------------

// File: rtl/ora_pkg.sv
// rtl/ora_pkg.sv - shared types and constants for the counting output response analyzer
package ora_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_TRANS = 1'b1;

endpackage

// File: rtl/ora_count_chan.sv
// rtl/ora_count_chan.sv - one analyzer channel: ones/transition counter with wrap or saturate
module ora_count_chan
    import ora_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic            mode,
    input  logic            sat_en,
    input  logic            din,
    output logic [BITS-1:0] count,
    output logic            ovf
);

    logic prev;
    logic inc;

    // prev starts at 0, so a leading 1 in transition mode counts as an edge
    assign inc = (mode == MODE_TRANS) ? (din ^ prev) : din;

    // Count one increment per enabled sample; all-ones either holds or wraps and flags overflow
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            prev  <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            prev <= din;
            if (inc) begin
                if (&count) begin
                    ovf <= 1'b1;
                    if (!sat_en) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ora_count_multi.sv
// rtl/ora_count_multi.sv - multi-channel counting ORA: window control, per-channel compare
module ora_count_multi
    import ora_pkg::*;
#(
    parameter int CH       = 4,
    parameter int BITS     = 16,
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic                sat_en,
    input  logic [LEN_BITS-1:0] test_len,
    input  logic [CH-1:0]       din,
    input  logic [CH*BITS-1:0]  golden,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CH-1:0]       fail_mask,
    output logic [CH-1:0]       ovf,
    output logic [CH*BITS-1:0]  counts
);

    state_t              state;
    state_t              state_nxt;
    logic [LEN_BITS-1:0] win;
    logic [LEN_BITS-1:0] len_q;
    logic                mode_q;
    logic                sat_q;
    logic                accept;
    logic                sample;
    logic [CH-1:0]       mismatch;

    // start is only honoured while no window is in flight
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign sample = (state == RUN);
    assign busy   = (state == RUN) || (state == CMP);
    assign done   = (state == DONE);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic [BITS-1:0] chan_count;

        ora_count_chan #(.BITS(BITS)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .clr    (accept),
            .en     (sample),
            .mode   (mode_q),
            .sat_en (sat_q),
            .din    (din[i]),
            .count  (chan_count),
            .ovf    (ovf[i])
        );

        assign counts[i*BITS +: BITS] = chan_count;
        assign mismatch[i]            = (chan_count != golden[i*BITS +: BITS]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a zero-length window skips straight to compare
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (test_len != '0) ? RUN : CMP;
                end
            end
            RUN: begin
                if (win == (len_q - LEN_BITS'(1))) begin
                    state_nxt = CMP;
                end
            end
            CMP:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window setup on start, sample counting in RUN, golden compare captured in CMP
    always_ff @(posedge clk) begin
        if (rst) begin
            win       <= '0;
            len_q     <= '0;
            mode_q    <= MODE_ONES;
            sat_q     <= 1'b0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            win       <= '0;
            len_q     <= test_len;
            mode_q    <= mode;
            sat_q     <= sat_en;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else if (state == RUN) begin
            win <= win + LEN_BITS'(1);
        end else if (state == CMP) begin
            fail_mask <= mismatch;
            pass      <= ~|mismatch;
        end
    end

endmodule

// File: tb/tb_ora_count_multi.sv
// tb/tb_ora_count_multi.sv - self-checking bench for ora_count_multi against a window-level model
module tb_ora_count_multi;

    localparam int CH       = 4;
    localparam int BITS     = 4;
    localparam int LEN_BITS = 16;
    localparam int MAXV     = (1 << BITS) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                mode;
    logic                sat_en;
    logic [LEN_BITS-1:0] test_len;
    logic [CH-1:0]       din;
    logic [CH*BITS-1:0]  golden;
    logic                busy;
    logic                done;
    logic                pass;
    logic [CH-1:0]       fail_mask;
    logic [CH-1:0]       ovf;
    logic [CH*BITS-1:0]  counts;

    int n_checks = 0;
    int n_err    = 0;

    ora_count_multi #(.CH(CH), .BITS(BITS), .LEN_BITS(LEN_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .sat_en    (sat_en),
        .test_len  (test_len),
        .din       (din),
        .golden    (golden),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .ovf       (ovf),
        .counts    (counts)
    );

    always #5 clk = ~clk;

    // Window-level model: m_k is the cycle index since start was accepted
    bit            m_active = 1'b0;
    int            m_k      = 0;
    int            m_len    = 0;
    bit            m_mode   = 1'b0;
    bit            m_sat    = 1'b0;
    int            n_inc [CH];
    bit            m_prev[CH];
    logic [CH-1:0] e_fail   = '0;
    bit            e_pass   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CH*BITS-1:0] m_counts();
        logic [CH*BITS-1:0] v;
        int                 c;
        v = '0;
        for (int i = 0; i < CH; i++) begin
            if (n_inc[i] <= MAXV) c = n_inc[i];
            else if (m_sat)       c = MAXV;
            else                  c = n_inc[i] % (MAXV + 1);
            v[i*BITS +: BITS] = BITS'(c);
        end
        return v;
    endfunction

    function automatic logic [CH-1:0] m_ovf();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = (n_inc[i] > MAXV);
        return v;
    endfunction

    initial begin
        for (int i = 0; i < CH; i++) begin
            n_inc[i]  = 0;
            m_prev[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active = 1'b0;
                m_k      = 0;
                for (int i = 0; i < CH; i++) begin
                    n_inc[i]  = 0;
                    m_prev[i] = 1'b0;
                end
                e_fail = '0;
                e_pass = 1'b0;
            end else if (start && (!m_active || m_k == m_len + 2)) begin
                m_active = 1'b1;
                m_k      = 1;
                m_mode   = mode;
                m_sat    = sat_en;
                m_len    = int'(test_len);
                for (int i = 0; i < CH; i++) begin
                    n_inc[i]  = 0;
                    m_prev[i] = 1'b0;
                end
                e_fail = '0;
                e_pass = 1'b0;
            end else if (m_active) begin
                if (m_k >= 1 && m_k <= m_len) begin
                    for (int i = 0; i < CH; i++) begin
                        if (m_mode) n_inc[i] += (din[i] != m_prev[i]) ? 1 : 0;
                        else        n_inc[i] += din[i] ? 1 : 0;
                        m_prev[i] = din[i];
                    end
                end else if (m_k == m_len + 1) begin
                    logic [CH*BITS-1:0] v;
                    v = m_counts();
                    for (int i = 0; i < CH; i++)
                        e_fail[i] = (v[i*BITS +: BITS] != golden[i*BITS +: BITS]);
                    e_pass = (e_fail == '0);
                end
                if (m_k < m_len + 2) m_k++;
            end
        end
    end

    // Every cycle, all outputs must match the model
    initial begin
        forever begin
            @(negedge clk);
            chk("busy",      64'(busy),      64'(m_active && m_k >= 1 && m_k <= m_len + 1));
            chk("done",      64'(done),      64'(m_active && m_k == m_len + 2));
            chk("counts",    64'(counts),    64'(m_counts()));
            chk("ovf",       64'(ovf),       64'(m_ovf()));
            chk("fail_mask", 64'(fail_mask), 64'(e_fail));
            chk("pass",      64'(pass),      64'(e_pass));
        end
    end

    // pat 0: constant dc; 1: random; 2: din[0] toggles starting at 1, din[1] held 1
    task automatic run_win(input logic m, input logic s, input int len,
                           input logic [CH*BITS-1:0] g, input int pat,
                           input logic [CH-1:0] dc, input int mid_start, output int lat);
        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        sat_en   = s;
        test_len = LEN_BITS'(len);
        golden   = g;
        din      = dc;
        lat      = -1;
        for (int c = 1; c <= len + 10; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            start = (c == mid_start);
            if (start) begin
                test_len = LEN_BITS'(len + 5);
                mode     = ~m;
            end
            case (pat)
                0:       din = dc;
                1:       din = CH'($urandom);
                default: din = {2'b00, 1'b1, (c % 2 == 1)};
            endcase
        end
        start = 1'b0;
    endtask

    int lat;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        sat_en   = 1'b0;
        test_len = '0;
        din      = '0;
        golden   = '0;
        repeat (2) @(negedge clk);
        chk("reset_counts", 64'(counts), 64'd0);
        chk("reset_busy_done", 64'({busy, done, pass}), 64'd0);
        rst = 1'b0;

        // ones count, matching golden
        run_win(1'b0, 1'b0, 8, {4'd0, 4'd8, 4'd0, 4'd8}, 0, 4'b0101, -1, lat);
        chk("t1_latency", 64'(lat), 64'd10);
        chk("t1_counts", 64'(counts), 64'({4'd0, 4'd8, 4'd0, 4'd8}));
        chk("t1_pass", 64'(pass), 64'd1);

        // transition count, back-to-back from DONE with a new mode
        run_win(1'b1, 1'b0, 6, '0, 2, 4'b0000, -1, lat);
        chk("t2_counts", 64'(counts), 64'({4'd0, 4'd0, 4'd1, 4'd6}));
        chk("t2_fail", 64'(fail_mask), 64'(4'b0011));

        // wrap vs saturate
        run_win(1'b0, 1'b0, 20, '0, 0, 4'hF, -1, lat);
        chk("t3_wrap_counts", 64'(counts), 64'({4{4'd4}}));
        chk("t3_wrap_ovf", 64'(ovf), 64'hF);
        run_win(1'b0, 1'b1, 20, '0, 0, 4'hF, -1, lat);
        chk("t3_sat_counts", 64'(counts), 64'({4{4'd15}}));
        chk("t3_sat_ovf", 64'(ovf), 64'hF);

        // single-channel mismatch
        run_win(1'b0, 1'b0, 8, {4'd0, 4'd1, 4'd0, 4'd8}, 0, 4'b0101, -1, lat);
        chk("t4_fail", 64'(fail_mask), 64'(4'b0100));
        chk("t4_pass", 64'(pass), 64'd0);
        chk("t4_ovf_cleared", 64'(ovf), 64'd0);

        // zero-length window
        run_win(1'b0, 1'b0, 0, '0, 0, 4'hF, -1, lat);
        chk("t4_len0_latency", 64'(lat), 64'd2);
        chk("t4_len0_counts", 64'(counts), 64'd0);
        chk("t4_len0_pass", 64'(pass), 64'd1);

        // start mid-RUN is ignored
        run_win(1'b0, 1'b0, 8, {4'd0, 4'd8, 4'd0, 4'd8}, 0, 4'b0101, 3, lat);
        chk("t5_latency", 64'(lat), 64'd10);
        chk("t5_pass", 64'(pass), 64'd1);

        // reset mid-RUN
        @(negedge clk);
        start    = 1'b1;
        mode     = 1'b0;
        test_len = LEN_BITS'(30);
        din      = 4'hF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_mid_counts", 64'(counts), 64'({4{4'd4}}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_counts", 64'(counts), 64'd0);
        chk("t5_rst_flags", 64'({busy, done, pass, fail_mask, ovf}), 64'd0);

        // random traffic: random starts, modes, lengths, data, occasional reset
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst      = ($urandom % 300 == 0);
            start    = ($urandom % 6 == 0);
            mode     = 1'($urandom);
            sat_en   = 1'($urandom);
            test_len = LEN_BITS'($urandom % 28);
            din      = CH'($urandom);
            golden   = m_counts();
            if ($urandom % 3 == 0)
                golden[($urandom % CH) * BITS] = ~golden[($urandom % CH) * BITS];
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
